// File: rtl/hud_bcd_converter_if.sv
// Request/result bundle for hud_bcd_converter.
// The neg signal exists only when HUD_BCD_SIGNED_CLAMP_EN is defined.
interface hud_bcd_converter_if #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;
    logic                  ovf;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
    logic                  neg;

    modport master (output start, bin_in, input busy, valid, bcd_out, blank, ovf, neg);
    modport slave  (input start, bin_in, output busy, valid, bcd_out, blank, ovf, neg);
`else
    modport master (output start, bin_in, input busy, valid, bcd_out, blank, ovf);
    modport slave  (input start, bin_in, output busy, valid, bcd_out, blank, ovf);
`endif
endinterface

// File: rtl/hud_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with saturation and a leading-zero blank mask.
// Optional HUD_BCD_SIGNED_CLAMP_EN: two's-complement input, negatives show as 0 with neg=1.
module hud_bcd_converter #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    hud_bcd_converter_if.slave bus
);
    localparam int unsigned       SW        = 4 * DIGITS;
    localparam int unsigned       CNT_W     = $clog2(BIN_W + 1);
    localparam int unsigned       MAX       = (32'd10 ** DIGITS) - 32'd1;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [BIN_W-1:0]    bin_sr;
    logic [SW-1:0]       scratch;
    logic [CNT_W-1:0]    cnt;
    logic                sat;
    logic [SW-1:0]       adj;
    logic [BIN_W-1:0]    load_val;
    logic                load_sat;
    logic [SW-1:0]       bcd_nxt;
    logic [DIGITS-1:0]   blank_nxt;
    logic                all_zero;
    logic [SW-1:0]       bcd_r;
    logic [DIGITS-1:0]   blank_r;
    logic                ovf_r;
    logic                valid_r;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
    logic                load_neg;
    logic                neg_pend;
    logic                neg_r;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction per digit, 4-bit wrap, before the shift.
    always_comb begin
        adj = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            else                           adj[4*d +: 4] = scratch[4*d +: 4];
        end
    end

    always_comb begin
        load_val = bus.bin_in;
        load_sat = 32'(bus.bin_in) > MAX;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
        load_neg = bus.bin_in[BIN_W-1];
        if (load_neg) begin
            load_val = '0;
            load_sat = 1'b0;
        end
`endif
    end

    // Blank scans from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        bcd_nxt   = sat ? {DIGITS{4'h9}} : scratch;
        blank_nxt = '0;
        all_zero  = 1'b1;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            all_zero             = all_zero & (bcd_nxt[4*(DIGITS-i) +: 4] == 4'd0);
            blank_nxt[DIGITS-i]  = all_zero;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            bcd_r    <= '0;
            blank_r  <= BLANK_RST;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
            neg_pend <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            valid_r <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    bin_sr   <= load_val;
                    scratch  <= '0;
                    cnt      <= CNT_W'(BIN_W);
                    sat      <= load_sat;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
                    neg_pend <= load_neg;
`endif
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {adj, bin_sr} << 1;
                    cnt               <= cnt - CNT_W'(1);
                end
                DONE: begin
                    bcd_r   <= bcd_nxt;
                    blank_r <= blank_nxt;
                    ovf_r   <= sat;
                    valid_r <= 1'b1;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
                    neg_r   <= neg_pend;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.valid   = valid_r;
    assign bus.bcd_out = bcd_r;
    assign bus.blank   = blank_r;
    assign bus.ovf     = ovf_r;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
    assign bus.neg     = neg_r;
`endif
endmodule

// File: tb/tb_hud_bcd_converter.sv
// Self-checking bench: default converter (10b/4 digits) and a narrow one (8b/2 digits)
// against an arithmetic decimal reference model.
module tb_hud_bcd_converter;
    logic Clk = 1'b0;
    logic Reset_n;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    hud_bcd_converter_if #(.BIN_W(10), .DIGITS(4)) bus_d ();
    hud_bcd_converter_if #(.BIN_W(8),  .DIGITS(2)) bus_s ();

    hud_bcd_converter #(.BIN_W(10), .DIGITS(4)) u_dut_d (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_d));
    hud_bcd_converter #(.BIN_W(8),  .DIGITS(2)) u_dut_s (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_s));

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1);
    end

    function automatic int unsigned p10(input int unsigned n);
        int unsigned r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Decimal reference: digits by division, blanks by magnitude comparison.
    function automatic void model(input int unsigned raw, input int unsigned bw, input int unsigned digits,
                                  output logic [31:0] bcd, output logic [31:0] blank,
                                  output logic ovf, output logic neg);
        int unsigned v = raw;
        neg = 1'b0;
`ifdef HUD_BCD_SIGNED_CLAMP_EN
        if (raw >= (32'd1 << (bw - 1))) begin
            v   = 0;
            neg = 1'b1;
        end
`endif
        ovf = (v > p10(digits) - 1);
        if (ovf) v = p10(digits) - 1;
        bcd   = '0;
        blank = '0;
        for (int unsigned d = 0; d < digits; d++) begin
            bcd[4*d +: 4] = 4'((v / p10(d)) % 10);
            if (d > 0 && v < p10(d)) blank[d] = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; optionally injects a second start on conversion cycle inj_at.
    task automatic run_d(input logic [9:0] v, input int unsigned inj_at, input logic [9:0] inj_v);
        logic [31:0] eb, ebl;
        logic eo, en;
        int unsigned n = 0, nb = 0;
        bit got = 1'b0;
        model(32'(v), 10, 4, eb, ebl, eo, en);
        bus_d.start  = 1'b1;
        bus_d.bin_in = v;
        while (!got && n < 40) begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                bus_d.start  = 1'b0;
                bus_d.bin_in = 10'($urandom);
            end
            if (inj_at != 0 && n == inj_at) begin
                bus_d.start  = 1'b1;
                bus_d.bin_in = inj_v;
            end
            if (inj_at != 0 && n == inj_at + 1) bus_d.start = 1'b0;
            if (bus_d.busy)  nb++;
            if (bus_d.valid) got = 1'b1;
        end
        check("d.valid_seen", 32'(got), 32'd1);
        check("d.latency", n, 32'd12);
        check("d.busy_cycles", nb, 32'd11);
        check("d.bcd_out", 32'(bus_d.bcd_out), eb);
        check("d.blank", 32'(bus_d.blank), ebl);
        check("d.ovf", 32'(bus_d.ovf), 32'(eo));
`ifdef HUD_BCD_SIGNED_CLAMP_EN
        check("d.neg", 32'(bus_d.neg), 32'(en));
`endif
    endtask

    task automatic run_s(input logic [7:0] v);
        logic [31:0] eb, ebl;
        logic eo, en;
        int unsigned n = 0, nb = 0;
        bit got = 1'b0;
        model(32'(v), 8, 2, eb, ebl, eo, en);
        bus_s.start  = 1'b1;
        bus_s.bin_in = v;
        while (!got && n < 40) begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                bus_s.start  = 1'b0;
                bus_s.bin_in = 8'($urandom);
            end
            if (bus_s.busy)  nb++;
            if (bus_s.valid) got = 1'b1;
        end
        check("s.valid_seen", 32'(got), 32'd1);
        check("s.latency", n, 32'd10);
        check("s.busy_cycles", nb, 32'd9);
        check("s.bcd_out", 32'(bus_s.bcd_out), eb);
        check("s.blank", 32'(bus_s.blank), ebl);
        check("s.ovf", 32'(bus_s.ovf), 32'(eo));
`ifdef HUD_BCD_SIGNED_CLAMP_EN
        check("s.neg", 32'(bus_s.neg), 32'(en));
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".d.busy"},  32'(bus_d.busy),    32'd0);
        check({tag, ".d.valid"}, 32'(bus_d.valid),   32'd0);
        check({tag, ".d.bcd"},   32'(bus_d.bcd_out), 32'h0000);
        check({tag, ".d.blank"}, 32'(bus_d.blank),   32'b1110);
        check({tag, ".d.ovf"},   32'(bus_d.ovf),     32'd0);
        check({tag, ".s.bcd"},   32'(bus_s.bcd_out), 32'h00);
        check({tag, ".s.blank"}, 32'(bus_s.blank),   32'b10);
`ifdef HUD_BCD_SIGNED_CLAMP_EN
        check({tag, ".d.neg"},   32'(bus_d.neg),     32'd0);
`endif
    endtask

    initial begin
        int unsigned vcnt;
        Reset_n      = 1'b0;
        bus_d.start  = 1'b0;
        bus_d.bin_in = '0;
        bus_s.start  = 1'b0;
        bus_s.bin_in = '0;
        #12;
        check_reset_values("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_d(10'd0, 0, '0);
        run_d(10'd100, 0, '0);
        run_d(10'd1023, 0, '0);
        run_d(10'd999, 0, '0);
        run_d(10'd1000, 0, '0);
        run_s(8'd150);
        run_s(8'd99);
        run_s(8'd7);
        run_s(8'd100);
        for (int i = 0; i < 10; i++) run_d(10'($urandom), 0, '0);
        for (int i = 0; i < 10; i++) run_s(8'($urandom));

        // Second start mid-conversion is dropped; back-to-back call starts on first IDLE cycle.
        run_d(10'd42, 3, 10'd500);
        run_d(10'd500, 0, '0);

        // Abort 777 during its 5th SHIFT cycle.
        bus_d.start  = 1'b1;
        bus_d.bin_in = 10'd777;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            bus_d.start = 1'b0;
        end
        Reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        vcnt = 0;
        repeat (15) begin
            @(negedge Clk);
            if (bus_d.valid) vcnt++;
        end
        check("abort.no_valid", vcnt, 32'd0);
        check("abort.bcd_held", 32'(bus_d.bcd_out), 32'h0000);
        run_d(10'd5, 0, '0);

`ifdef HUD_BCD_SIGNED_CLAMP_EN
        run_d(10'h3F6, 0, '0);
        run_d(10'd100, 0, '0);
        run_s(8'h80);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hud_bcd_converter.md
Name: hud_bcd_converter

Overview:
- Sequential binary-to-BCD converter. Sits downstream of the game top's score and player-blood arithmetic, and upstream of the HexDriver seven-segment instances.
- Samples a binary value on a start strobe, normally game_frame_clk_rising_edge. Converts it by iterative shift-add-3 (double dabble), one bit per clock.
- Presents registered BCD digits, a leading-zero blank mask and an overflow flag, so HEX shows decimal instead of hex.
- One instance per displayed quantity: Total_Score, Player_Blood.

Parameters:
- BIN_W, 10, width of binary input (1..16).
- DIGITS, 4, number of BCD output digits (1..5).

Ports:
- Clk  input  1  system clock (CLOCK_50 domain).
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to convert bin_in.
- bin_in  input  BIN_W  binary value, sampled only when start is accepted.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when bcd_out, blank and ovf update.
- bcd_out  output  4*DIGITS  digit d occupies bits [4d+3:4d]; digit 0 is least significant.
- blank  output  DIGITS  bit d=1 means digit d is a leading zero; bit 0 is always 0.
- ovf  output  1  last accepted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (async assert, sync-to-Clk release is the integrator's job):
  - state=IDLE, busy=0, valid=0, bcd_out=0, ovf=0.
  - blank = all ones except bit 0 = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: latch bin_in into shift register, clear BCD scratch (4*DIGITS bits), load count=BIN_W.
  - Compute sat = (bin_in > MAX) with MAX = 10^DIGITS-1, evaluated at full BIN_W width with no truncation.
  - Go to SHIFT.
- SHIFT, one iteration per clock:
  - Each scratch digit >= 5 gets +3 (4-bit, no carry between digits before the shift).
  - Then {scratch,bin} shifts left by 1; count decrements.
  - When count reaches 1 in this cycle, next state is DONE.
  - Exactly BIN_W SHIFT cycles occur.
- DONE (one cycle):
  - If sat, bcd_out = all digits 9 and ovf=1. Else bcd_out = scratch and ovf=0.
  - blank computed from the new bcd_out: bit d=1 iff digits DIGITS-1..d are all zero and d>0.
  - valid=1 this cycle only. Return to IDLE.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- Latency: start sampled on edge E. bcd_out, blank and ovf change on edge E+BIN_W+1, and valid is high for the cycle after that edge. Throughput: one conversion per BIN_W+2 cycles.
- start while busy=1 is ignored; no queueing. bin_in changes during a conversion have no effect.
- start in the same cycle DONE returns to IDLE is ignored. It is accepted on the first IDLE cycle only.
- Outputs hold their last values between conversions. valid is never high in two consecutive cycles.
- Reset_n low mid-SHIFT: conversion aborted, all outputs take reset values immediately (combinationally from reset, not on the next edge). No valid is produced for the aborted value.

Optional Feature:
- Macro: HUD_BCD_SIGNED_CLAMP_EN, plus an extra output neg (1 bit, reset 0).
- Defined:
  - bin_in is two's complement. This covers Player_Blood going below zero after damage.
  - If bin_in MSB=1 at accept: the value converts as 0, ovf=0, and neg=1 at DONE. Otherwise neg=0 at DONE.
  - sat compares the magnitude of non-negative values only.
- Not defined: bin_in is unsigned, there is no neg port, and behaviour is exactly as above.

Test Plan:
- Defaults (BIN_W=10, DIGITS=4), start with bin_in=0 -> valid after 11 edges, bcd_out=16'h0000, blank=4'b1110, ovf=0; busy high for exactly 11 cycles.
- bin_in=100 -> bcd_out=16'h0100, blank=4'b1000; bin_in=1023 -> bcd_out=16'h1023, blank=4'b0000.
- DIGITS=2, BIN_W=8, bin_in=150 -> bcd_out=8'h99, ovf=1; then bin_in=99 -> bcd_out=8'h99, ovf=0; then bin_in=7 -> bcd_out=8'h07, blank=2'b10.
- Convert 42, pulse start with 500 on cycle 3 of the conversion -> single valid, bcd_out=16'h0042; 500 is not converted. Start on the first IDLE cycle -> 16'h0500.
- Assert Reset_n=0 during the 5th SHIFT cycle of 777 -> outputs at reset values immediately, no valid for 777. Release, convert 5 -> 16'h0005, blank=4'b1110.
- With HUD_BCD_SIGNED_CLAMP_EN, bin_in=10'h3F6 (-10) -> bcd_out=16'h0000, neg=1, ovf=0. Then bin_in=100 -> bcd_out=16'h0100, neg=0.
